// File: rtl/mips_div_pkg.sv
// Shared types and constants for the iterative MIPS divider.
package mips_div_pkg;

  localparam int unsigned DIV_ITERS = 32;
  localparam int unsigned CNT_W     = 5;

  typedef enum logic [2:0] {
    StIdle,
    StPrep,
    StRun,
    StFix,
    StDone
  } divState_e;

endpackage

// File: rtl/mips_div_step.sv
// One restoring-division iteration: trial-subtract the divisor from the shifted partial remainder.
module mips_div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0]   remShift,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] remNext,
  output logic             qBit
);

  // One guard bit above the WIDTH+1-bit operands carries the borrow, which is the sign.
  logic [WIDTH+1:0] diff;

  assign diff    = {1'b0, remShift} - {2'b00, divisor};
  assign qBit    = ~diff[WIDTH+1];
  assign remNext = qBit ? diff[WIDTH-1:0] : remShift[WIDTH-1:0];

endmodule

// File: rtl/mips_div_unit.sv
// Iterative 32-cycle restoring divider for DIV/DIVU (HI = remainder, LO = quotient).
// Define MIPS_DIV_SIGNED_EN to honour is_signed; otherwise every operation is unsigned.
module mips_div_unit
  import mips_div_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  divState_e        state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] partRem;
  logic [WIDTH-1:0] dvdQuo;   // dividend bits shift out the top as quotient bits shift in
  logic [WIDTH-1:0] dsrReg;
  logic [WIDTH-1:0] origDvd;
  logic [WIDTH-1:0] remNext;
  logic             qBit;

`ifdef MIPS_DIV_SIGNED_EN
  logic signedOp;
  logic qNeg;
  logic rNeg;
`else
  logic unusedSigned;
  assign unusedSigned = is_signed;
`endif

  mips_div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .remShift({partRem, dvdQuo[WIDTH-1]}),
    .divisor (dsrReg),
    .remNext (remNext),
    .qBit    (qBit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= StIdle;
      cnt         <= '0;
      partRem     <= '0;
      dvdQuo      <= '0;
      dsrReg      <= '0;
      origDvd     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
`ifdef MIPS_DIV_SIGNED_EN
      signedOp    <= 1'b0;
      qNeg        <= 1'b0;
      rNeg        <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start) begin
            dvdQuo  <= dividend;
            dsrReg  <= divisor;
            origDvd <= dividend;
`ifdef MIPS_DIV_SIGNED_EN
            signedOp <= is_signed;
`endif
            busy    <= 1'b1;
            state   <= StPrep;
          end
        end
        StPrep: begin
`ifdef MIPS_DIV_SIGNED_EN
          if (signedOp) begin
            if (dvdQuo[WIDTH-1]) dvdQuo <= -dvdQuo;
            if (dsrReg[WIDTH-1]) dsrReg <= -dsrReg;
            qNeg <= dvdQuo[WIDTH-1] ^ dsrReg[WIDTH-1];
            rNeg <= dvdQuo[WIDTH-1];
          end else begin
            qNeg <= 1'b0;
            rNeg <= 1'b0;
          end
`endif
          partRem <= '0;
          cnt     <= '0;
          state   <= StRun;
        end
        StRun: begin
          partRem <= remNext;
          dvdQuo  <= {dvdQuo[WIDTH-2:0], qBit};
          cnt     <= cnt + 1'b1;
          if (cnt == CNT_W'(DIV_ITERS - 1)) state <= StFix;
        end
        StFix: begin
          busy        <= 1'b0;
          done        <= 1'b1;
          state       <= StDone;
          div_by_zero <= (dsrReg == '0);
          // A zero divisor yields all-ones naturally; the remainder is the untouched dividend.
          if (dsrReg == '0) begin
            quotient  <= dvdQuo;
            remainder <= origDvd;
          end else begin
`ifdef MIPS_DIV_SIGNED_EN
            quotient  <= qNeg ? -dvdQuo : dvdQuo;
            remainder <= rNeg ? -partRem : partRem;
`else
            quotient  <= dvdQuo;
            remainder <= partRem;
`endif
          end
        end
        StDone: state <= StIdle;
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_div_unit.sv
// Directed self-checking bench for mips_div_unit; expectations follow MIPS_DIV_SIGNED_EN.
module tb_mips_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int checks   = 0;
  int failures = 0;

  mips_div_unit #(
    .WIDTH(32)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .is_signed  (is_signed),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Issue one divide; optionally pulse a second start at lat == glitchAt while the first runs.
  task automatic runDiv(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input int glitchAt, output int lat, output int busyCnt);
    @(negedge clk);
    start     = 1'b1;
    is_signed = sgn;
    dividend  = a;
    divisor   = b;
    @(posedge clk);
    #1 start = 1'b0;
    lat     = 0;
    busyCnt = 0;
    while (lat < 100) begin
      @(negedge clk);
      if (lat == glitchAt) begin
        start     = 1'b1;
        is_signed = 1'b0;
        dividend  = 32'd5;
        divisor   = 32'd1;
      end else if (lat == glitchAt + 1) begin
        start = 1'b0;
      end
      if (done) break;
      busyCnt += int'(busy);
      @(posedge clk);
      lat++;
    end
  endtask

  task automatic expectDiv(input string tag, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] q, input logic [31:0] r,
                           input logic dbz);
    int lat;
    int bc;
    runDiv(sgn, a, b, -10, lat, bc);
    checkVal({tag, "_lat"}, 32'(lat), 32'd34);
    checkVal({tag, "_q"}, quotient, q);
    checkVal({tag, "_r"}, remainder, r);
    checkVal({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, dbz});
  endtask

  initial begin
    int lat;
    int bc;
    int doneSeen;
    reset     = 1'b1;
    start     = 1'b0;
    is_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkVal("rst_busy", {31'd0, busy}, 32'd0);
    checkVal("rst_done", {31'd0, done}, 32'd0);
    checkVal("rst_q", quotient, 32'd0);
    checkVal("rst_r", remainder, 32'd0);
    checkVal("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    reset = 1'b0;

    // Basic unsigned with full timing checks
    runDiv(1'b0, 32'd100, 32'd7, -10, lat, bc);
    checkVal("u100_7_lat", 32'(lat), 32'd34);
    checkVal("u100_7_busycnt", 32'(bc), 32'd34);
    checkVal("u100_7_busy_at_done", {31'd0, busy}, 32'd0);
    checkVal("u100_7_q", quotient, 32'd14);
    checkVal("u100_7_r", remainder, 32'd2);
    checkVal("u100_7_dbz", {31'd0, div_by_zero}, 32'd0);
    @(negedge clk);
    checkVal("u100_7_done_pulse", {31'd0, done}, 32'd0);
    checkVal("u100_7_q_hold", quotient, 32'd14);

`ifdef MIPS_DIV_SIGNED_EN
    expectDiv("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    expectDiv("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0);
    expectDiv("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
`else
    expectDiv("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1, 1'b0);
    expectDiv("s_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'd0, 32'd7, 1'b0);
    expectDiv("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
`endif
    expectDiv("u_m7_2", 1'b0, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1, 1'b0);
    expectDiv("u_dz", 1'b0, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 32'h0000_1234, 1'b1);
    expectDiv("s_dz", 1'b1, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b1);
    expectDiv("u_after_dz", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    expectDiv("u_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0);
    expectDiv("u_small_big", 1'b0, 32'd5, 32'hFFFF_FFFF, 32'd0, 32'd5, 1'b0);

    // Second start while busy must be ignored
    runDiv(1'b0, 32'd1000, 32'd10, 11, lat, bc);
    checkVal("ign_lat", 32'(lat), 32'd34);
    checkVal("ign_q", quotient, 32'd100);
    checkVal("ign_r", remainder, 32'd0);
    repeat (3) @(negedge clk);
    checkVal("ign_idle_busy", {31'd0, busy}, 32'd0);

    // Reset in the middle of an operation
    @(negedge clk);
    start     = 1'b1;
    is_signed = 1'b0;
    dividend  = 32'd77;
    divisor   = 32'd3;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (19) @(posedge clk);
    @(negedge clk);
    checkVal("mid_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    checkVal("mid_rst_busy", {31'd0, busy}, 32'd0);
    checkVal("mid_rst_done", {31'd0, done}, 32'd0);
    checkVal("mid_rst_q", quotient, 32'd0);
    checkVal("mid_rst_r", remainder, 32'd0);
    checkVal("mid_rst_dbz", {31'd0, div_by_zero}, 32'd0);
    reset    = 1'b0;
    doneSeen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      doneSeen += int'(done) + int'(busy);
    end
    checkVal("mid_no_done", 32'(doneSeen), 32'd0);
    expectDiv("post_rst", 1'b0, 32'd77, 32'd3, 32'd25, 32'd2, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
